// File: rtl/ttfs_spike_scanner.sv
// TTFS spike scanner: walks the spike-time SRAM, matches first-spike stamps against
// the current tick, and queues matching neuron addresses in a show-ahead FIFO.
module ttfs_spike_scanner #(
  parameter int unsigned N          = 256,
  parameter int unsigned INPUT_RESO = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned M         = $clog2(N),
  localparam int unsigned SPW       = 32 / INPUT_RESO,
  localparam int unsigned AW        = $clog2(N / SPW),
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_i,
  input  logic [INPUT_RESO-1:0] tick_i,
  input  logic                  mode_i,
  input  logic                  clear_i,
  output logic                  mem_en_o,
  output logic [AW-1:0]         mem_addr_o,
  input  logic [31:0]           mem_rdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [M-1:0]          out_addr_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CW-1:0]         fifo_count_o
);

  localparam int unsigned NW = N / SPW;
  localparam int unsigned JW = $clog2(SPW);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, READ, WAIT, EVAL, DRAIN} state_t;

  state_t                  state;
  logic [AW-1:0]           w;
  logic [JW-1:0]           j;
  logic [31:0]             word_q;
  logic [INPUT_RESO-1:0]   tick_q;
  logic                    mode_q;
  logic [N-1:0]            fired;

  logic [M-1:0]            fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;

  logic [INPUT_RESO-1:0]   stamp;
  logic [M-1:0]            n;
  logic                    match;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic                    advance;
  logic [CW-1:0]           count_nxt;

  // Match decode for the stamp currently under evaluation
  always_comb begin
    stamp     = word_q[int'(j) * INPUT_RESO +: INPUT_RESO];
    n         = {w, j};
    match     = 1'b0;
    full      = (fifo_count_o == CW'(FIFO_DEPTH));
    if (stamp != '1) begin
      if (mode_q) match = (stamp <= tick_q) && !fired[n];
      else        match = (stamp == tick_q);
    end
    push      = (state == EVAL) && match && !full;
    advance   = !match || push;
    pop       = out_valid_o && out_ready_i;
    count_nxt = fifo_count_o + CW'(push) - CW'(pop);
  end

  // Scan FSM with registered SRAM/status outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      w          <= '0;
      j          <= '0;
      word_q     <= '0;
      tick_q     <= '0;
      mode_q     <= 1'b0;
      fired      <= '0;
      mem_en_o   <= 1'b0;
      mem_addr_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      mem_en_o   <= 1'b0;
      mem_addr_o <= '0;
      done_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_i) fired <= '0;
          if (start_i) begin
            tick_q     <= tick_i;
            mode_q     <= mode_i;
            w          <= '0;
            state      <= READ;
            mem_en_o   <= 1'b1;
            busy_o     <= 1'b1;
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          word_q <= mem_rdata_i;
          j      <= '0;
          state  <= EVAL;
        end
        EVAL: begin
          if (push && mode_q) fired[n] <= 1'b1;
          if (advance) begin
            if (j == JW'(SPW - 1)) begin
              j <= '0;
              if (w == AW'(NW - 1)) begin
                state <= DRAIN;
              end else begin
                w          <= w + 1'b1;
                state      <= READ;
                mem_en_o   <= 1'b1;
                mem_addr_o <= w + 1'b1;
              end
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (fifo_count_o == '0) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; full is judged before this cycle's pop
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count_o <= '0;
      out_valid_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count_o <= count_nxt;
      out_valid_o  <= (count_nxt != '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= n;
  end

  assign out_addr_o = out_valid_o ? fifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_ttfs_spike_scanner.sv
// Scoreboard bench for ttfs_spike_scanner: directed scans push expected addresses,
// a negedge monitor pops and compares every accepted FIFO head.
module tb_ttfs_spike_scanner;

  localparam int NW   = 64;
  localparam int SCAN = NW * 6;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  tick_i = '0;
  logic        mode_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        mem_en_o;
  logic [5:0]  mem_addr_o;
  logic [31:0] mem_rdata_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [7:0]  out_addr_o;
  logic        busy_o;
  logic        done_o;
  logic [4:0]  fifo_count_o;

  logic [31:0] sram [NW];
  int          exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  ttfs_spike_scanner dut (
    .CLK(CLK), .RST(RST), .start_i(start_i), .tick_i(tick_i), .mode_i(mode_i),
    .clear_i(clear_i), .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_addr_o(out_addr_o), .busy_o(busy_o), .done_o(done_o), .fifo_count_o(fifo_count_o)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (mem_en_o) mem_rdata_i <= sram[mem_addr_o];

  function automatic void check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: every accepted head is compared with the oldest expected address
  always @(negedge CLK) begin
    if (!RST && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) check("unexpected_out", int'(out_addr_o), -1);
      else check("out_addr", int'(out_addr_o), exp_q.pop_front());
    end
  end

  task automatic step(input int c);
    repeat (c) begin @(posedge CLK); #1; end
  endtask

  task automatic do_start(input logic [7:0] t, input logic m);
    tick_i = t; mode_i = m; start_i = 1'b1;
    step(1);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int k);
    k = 0;
    do begin step(1); k++; end while (!done_o && k < budget);
    if (!done_o) check("done_timeout", k, -1);
  endtask

  task automatic fill_sram(input logic [31:0] v);
    for (int i = 0; i < NW; i++) sram[i] = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    fill_sram(32'hFFFF_FFFF);

    // Reset state
    step(2);
    check("rst_busy", int'(busy_o), 0);
    check("rst_valid", int'(out_valid_o), 0);
    check("rst_count", int'(fifo_count_o), 0);
    check("rst_mem_en", int'(mem_en_o), 0);
    check("rst_done", int'(done_o), 0);
    RST = 1'b0;
    step(1);

    // Exact mode: single match at neuron 0, scan latency 385 from first READ
    sram[0] = 32'hFFFE_FFAF;
    out_ready_i = 1'b1;
    exp_q.push_back(0);
    do_start(8'hAF, 1'b0);
    check("t1_mem_en", int'(mem_en_o), 1);
    check("t1_mem_addr", int'(mem_addr_o), 0);
    wait_done(2000, k);
    check("t1_latency", k, SCAN + 1);
    check("t1_busy_at_done", int'(busy_o), 0);
    step(1);
    check("t1_done_pulse", int'(done_o), 0);
    check("t1_drained", exp_q.size(), 0);

    // No-match scan with an ignored mid-scan start pulse
    do_start(8'h10, 1'b0);
    k = 0;
    do begin
      start_i = (k == 50);
      tick_i = 8'hFE;
      mode_i = 1'b1;
      step(1); k++;
    end while (!done_o && k < 2000);
    start_i = 1'b0;
    check("t6_latency", k, SCAN + 1);
    step(3);
    check("t6_idle_after", int'(busy_o), 0);

    // Cumulative mode, fired bitmap, clear
    exp_q.push_back(0); exp_q.push_back(2);
    do_start(8'hFE, 1'b1);
    wait_done(2000, k);
    check("t2_scan1_drained", exp_q.size(), 0);
    do_start(8'hFE, 1'b1);
    wait_done(2000, k);
    check("t2_scan2_latency", k, SCAN + 1);
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    exp_q.push_back(0); exp_q.push_back(2);
    do_start(8'hFE, 1'b1);
    wait_done(2000, k);
    check("t2_scan3_drained", exp_q.size(), 0);

    // Backpressure: fill FIFO, stall, then pop/push at boundary counts
    fill_sram(32'h0000_0000);
    out_ready_i = 1'b0;
    for (int i = 0; i < 256; i++) exp_q.push_back(i);
    do_start(8'h00, 1'b0);
    k = 0;
    while (fifo_count_o != 5'd16 && k < 500) begin step(1); k++; end
    check("t3_full", int'(fifo_count_o), 16);
    step(5);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_en_o) k++;
      step(1);
    end
    check("t3_stall_no_reads", k, 0);
    check("t3_hold_count", int'(fifo_count_o), 16);
    check("t3_hold_busy", int'(busy_o), 1);
    out_ready_i = 1'b1;
    step(1);
    check("t5_pop_when_full", int'(fifo_count_o), 15);
    step(1);
    check("t5_push_pop_15", int'(fifo_count_o), 15);
    wait_done(4000, k);
    check("t3_all_out", exp_q.size(), 0);

    // Reset mid-scan at word 10 with a non-empty FIFO
    fill_sram(32'hFFFF_FFFF);
    sram[2] = 32'h0000_0000;
    out_ready_i = 1'b0;
    for (int i = 8; i < 12; i++) exp_q.push_back(i);
    do_start(8'h00, 1'b0);
    k = 0;
    while (!(mem_en_o && mem_addr_o == 6'd10) && k < 500) begin step(1); k++; end
    step(2);
    check("t4_pre_count", int'(fifo_count_o), 4);
    exp_q.delete();
    RST = 1'b1;
    step(1);
    check("t4_busy", int'(busy_o), 0);
    check("t4_valid", int'(out_valid_o), 0);
    check("t4_count", int'(fifo_count_o), 0);
    RST = 1'b0;
    out_ready_i = 1'b1;
    sram[2] = 32'hFFFF_FFFF;
    step(1);
    do_start(8'h00, 1'b0);
    check("t4_restart_en", int'(mem_en_o), 1);
    check("t4_restart_addr", int'(mem_addr_o), 0);
    wait_done(2000, k);
    check("t4_latency", k, SCAN + 1);

    step(3);
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
